// File: rtl/mc_control_hs_if.sv
// Controller <-> datapath/memory/multiplier signal bundle for the multicycle MIPS-subset controller.
// The master side is the controller; the slave side is the datapath and its handshake partners.
interface mc_control_hs_if #(
   parameter int ALUOP_W = 3
);
   logic [5:0]         Opcode;
   logic [5:0]         funct;
   logic               MemReady;
   logic               MulDone;
   logic               IorD;
   logic               ALUSrcA;
   logic               IRWrite;
   logic               MemWrite;
   logic               PCWrite;
   logic               RegWrite;
   logic               Ori;
   logic               Branch;
   logic [1:0]         ALUSrcB;
   logic [1:0]         PCSrc;
   logic [1:0]         MemtoReg;
   logic [1:0]         RegDst;
   logic [ALUOP_W-1:0] ALUOp;
   logic               MemReq;
   logic               MulStart;
   logic               Trap;
   logic [4:0]         State;

   modport master (
      input  Opcode, funct, MemReady, MulDone,
      output IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Ori, Branch,
             ALUSrcB, PCSrc, MemtoReg, RegDst, ALUOp, MemReq, MulStart, Trap, State
   );

   modport slave (
      output Opcode, funct, MemReady, MulDone,
      input  IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Ori, Branch,
             ALUSrcB, PCSrc, MemtoReg, RegDst, ALUOp, MemReq, MulStart, Trap, State
   );
endinterface

// File: rtl/mc_control_hs.sv
// Multicycle MIPS-subset main controller: Moore state decode with Mealy MemReady qualifiers in FETCH,
// variable-latency memory and multiplier handshakes, and a one-cycle trap on illegal opcode or timeout.
module mc_control_hs #(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int MUL_TIMEOUT = 0,
   parameter int CNT_W       = 8
) (
   input logic            clk,
   input logic            rst_n,
   mc_control_hs_if.master bus
);

   typedef enum logic [4:0] {
      S_FETCH    = 5'd0,
      S_DECODE   = 5'd1,
      S_EXEC     = 5'd2,
      S_ALUWB    = 5'd3,
      S_IMMEX    = 5'd4,
      S_IMMWB    = 5'd5,
      S_BRANCH   = 5'd6,
      S_JUMP     = 5'd7,
      S_JAL      = 5'd8,
      S_JR       = 5'd9,
      S_MEMADR   = 5'd10,
      S_MEMREAD  = 5'd11,
      S_MEMWB    = 5'd12,
      S_MEMWRITE = 5'd13,
      S_MULSTART = 5'd14,
      S_MULWAIT  = 5'd15,
      S_TRAP     = 5'd16
   } state_t;

   localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_MUL  = ALUOP_W'(5);

   localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_TIMEOUT == 0) ? 0 : MUL_TIMEOUT - 1);
   localparam bit               MUL_TIMED = (MUL_TIMEOUT != 0);

   state_t           state, state_next, dec_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             mem_expired, mul_expired;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_FETCH;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   assign mem_expired = (cnt == MEM_LAST);
   assign mul_expired = MUL_TIMED && (cnt == MUL_LAST);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH: begin
            if (bus.MemReady)      state_next = S_DECODE;
            else if (mem_expired)  state_next = S_TRAP;
         end
         S_DECODE: begin
            case (bus.Opcode)
               6'h00:                      state_next = (bus.funct == 6'h08) ? S_JR : S_EXEC;
               6'h08, 6'h09, 6'h0a, 6'h0d: state_next = S_IMMEX;
               6'h04:                      state_next = S_BRANCH;
               6'h02:                      state_next = S_JUMP;
               6'h03:                      state_next = S_JAL;
               6'h23, 6'h2b:               state_next = S_MEMADR;
               6'h1c:                      state_next = S_MULSTART;
               default:                    state_next = S_TRAP;
            endcase
         end
         S_EXEC:     state_next = S_ALUWB;
         S_IMMEX:    state_next = S_IMMWB;
         S_MEMADR:   state_next = (bus.Opcode == 6'h23) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (bus.MemReady)      state_next = S_MEMWB;
            else if (mem_expired)  state_next = S_TRAP;
         end
         S_MEMWRITE: begin
            if (bus.MemReady)      state_next = S_FETCH;
            else if (mem_expired)  state_next = S_TRAP;
         end
         S_MULSTART: state_next = S_MULWAIT;
         S_MULWAIT: begin
            if (bus.MulDone)       state_next = S_ALUWB;
            else if (mul_expired)  state_next = S_TRAP;
         end
         default:    state_next = S_FETCH;
      endcase
   end

   // Any state change clears the counter, so only the wait states ever accumulate a count.
   always_comb begin
      cnt_next = '0;
      if (state_next == state) cnt_next = (&cnt) ? cnt : cnt + 1'b1;
   end

   // While reset is held the datapath sees FETCH controls even though State still shows the old state.
   assign dec_state = rst_n ? state : S_FETCH;

   always_comb begin
      bus.IorD     = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.Ori      = 1'b0;
      bus.Branch   = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.PCSrc    = 2'b00;
      bus.MemtoReg = 2'b00;
      bus.RegDst   = 2'b00;
      bus.ALUOp    = ALU_ADD;
      bus.MemReq   = 1'b0;
      bus.MulStart = 1'b0;
      bus.Trap     = 1'b0;
      bus.State    = state;
      case (dec_state)
         S_FETCH: begin
            bus.MemReq  = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = rst_n & bus.MemReady;
            bus.PCWrite = rst_n & bus.MemReady;
         end
         S_DECODE:   bus.ALUSrcB = 2'b11;
         S_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = ALU_FUNC;
         end
         S_ALUWB: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = 2'b01;
         end
         S_IMMEX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            case (bus.Opcode)
               6'h0a:   bus.ALUOp = ALU_SLT;
               6'h0d: begin
                  bus.ALUOp = ALU_OR;
                  bus.Ori   = 1'b1;
               end
               default: bus.ALUOp = ALU_ADD;
            endcase
         end
         S_IMMWB: begin
            bus.RegWrite = 1'b1;
            bus.Ori      = (bus.Opcode == 6'h0d);
         end
         S_BRANCH: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = ALU_SUB;
            bus.PCSrc   = 2'b01;
            bus.Branch  = 1'b1;
         end
         S_JUMP: begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 2'b10;
         end
         S_JAL: begin
            bus.PCWrite  = 1'b1;
            bus.PCSrc    = 2'b10;
            bus.RegWrite = 1'b1;
            bus.RegDst   = 2'b10;
            bus.MemtoReg = 2'b10;
         end
         S_JR: begin
            bus.ALUSrcA = 1'b1;
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 2'b11;
         end
         S_MEMADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         S_MEMREAD: begin
            bus.IorD   = 1'b1;
            bus.MemReq = 1'b1;
         end
         S_MEMWB: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 2'b01;
         end
         S_MEMWRITE: begin
            bus.IorD     = 1'b1;
            bus.MemReq   = 1'b1;
            bus.MemWrite = 1'b1;
         end
         S_MULSTART: begin
            bus.ALUSrcA  = 1'b1;
            bus.ALUOp    = ALU_MUL;
            bus.MulStart = 1'b1;
         end
         S_MULWAIT: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = ALU_MUL;
         end
         S_TRAP: begin
            bus.Trap    = 1'b1;
            bus.PCWrite = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_hs.sv
// Bench for mc_control_hs: two instances (default timeouts, and MEM_TIMEOUT=4/MUL_TIMEOUT=3) share stimulus;
// a cycle-level model is compared on every negedge, plus literal checks on recorded traces.
module tb_mc_control_hs;

   typedef struct packed {
      logic       IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Ori, Branch;
      logic [1:0] ALUSrcB, PCSrc, MemtoReg, RegDst;
      logic [2:0] ALUOp;
      logic       MemReq, MulStart, Trap;
      logic [4:0] State;
   } outs_t;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       mem_ready, mul_done;
   logic       cmp_en, log_en;

   int checks = 0;
   int errors = 0;

   int mem_to [2] = '{15, 4};
   int mul_to [2] = '{0, 3};
   int ph     [2] = '{0, 0};
   int wt     [2] = '{0, 0};

   outs_t act [2];
   outs_t tr_a [$];
   outs_t tr_b [$];

   mc_control_hs_if #(.ALUOP_W(3)) ifa ();
   mc_control_hs_if #(.ALUOP_W(3)) ifb ();

   mc_control_hs dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
   mc_control_hs #(.ALUOP_W(3), .MEM_TIMEOUT(4), .MUL_TIMEOUT(3), .CNT_W(8))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

   assign ifa.Opcode = opcode;   assign ifb.Opcode = opcode;
   assign ifa.funct = funct;     assign ifb.funct = funct;
   assign ifa.MemReady = mem_ready; assign ifb.MemReady = mem_ready;
   assign ifa.MulDone = mul_done;   assign ifb.MulDone = mul_done;

   assign act[0] = {ifa.IorD, ifa.ALUSrcA, ifa.IRWrite, ifa.MemWrite, ifa.PCWrite, ifa.RegWrite,
                    ifa.Ori, ifa.Branch, ifa.ALUSrcB, ifa.PCSrc, ifa.MemtoReg, ifa.RegDst,
                    ifa.ALUOp, ifa.MemReq, ifa.MulStart, ifa.Trap, ifa.State};
   assign act[1] = {ifb.IorD, ifb.ALUSrcA, ifb.IRWrite, ifb.MemWrite, ifb.PCWrite, ifb.RegWrite,
                    ifb.Ori, ifb.Branch, ifb.ALUSrcB, ifb.PCSrc, ifb.MemtoReg, ifb.RegDst,
                    ifb.ALUOp, ifb.MemReq, ifb.MulStart, ifb.Trap, ifb.State};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Model: which phase of the instruction the controller is in, and how long it has sat there.
   function automatic int model_next(int p, int w, int mto, int uto, logic rdy, logic done,
                                     logic [5:0] op, logic [5:0] fn);
      case (p)
         0:  return rdy ? 1 : (w == mto - 1) ? 16 : 0;
         1: begin
            if (op == 6'h00) return (fn == 6'h08) ? 9 : 2;
            if (op == 6'h08 || op == 6'h09 || op == 6'h0a || op == 6'h0d) return 4;
            if (op == 6'h04) return 6;
            if (op == 6'h02) return 7;
            if (op == 6'h03) return 8;
            if (op == 6'h23 || op == 6'h2b) return 10;
            if (op == 6'h1c) return 14;
            return 16;
         end
         2:  return 3;
         4:  return 5;
         10: return (op == 6'h23) ? 11 : 13;
         11: return rdy ? 12 : (w == mto - 1) ? 16 : 11;
         13: return rdy ? 0 : (w == mto - 1) ? 16 : 13;
         14: return 15;
         15: return done ? 3 : (uto != 0 && w == uto - 1) ? 16 : 15;
         default: return 0;
      endcase
   endfunction

   function automatic outs_t model_out(int p, logic rst, logic rdy, logic [5:0] op);
      outs_t o;
      int d;
      o = '0;
      d = rst ? p : 0;
      o.State = 5'(p);
      case (d)
         0:  begin o.MemReq = 1; o.ALUSrcB = 2'd1; o.IRWrite = rst & rdy; o.PCWrite = rst & rdy; end
         1:  o.ALUSrcB = 2'd3;
         2:  begin o.ALUSrcA = 1; o.ALUOp = 3'd2; end
         3:  begin o.RegWrite = 1; o.RegDst = 2'd1; end
         4:  begin
            o.ALUSrcA = 1; o.ALUSrcB = 2'd2;
            o.ALUOp = (op == 6'h0a) ? 3'd4 : (op == 6'h0d) ? 3'd3 : 3'd0;
            o.Ori = (op == 6'h0d);
         end
         5:  begin o.RegWrite = 1; o.Ori = (op == 6'h0d); end
         6:  begin o.ALUSrcA = 1; o.ALUOp = 3'd1; o.PCSrc = 2'd1; o.Branch = 1; end
         7:  begin o.PCWrite = 1; o.PCSrc = 2'd2; end
         8:  begin o.PCWrite = 1; o.PCSrc = 2'd2; o.RegWrite = 1; o.RegDst = 2'd2; o.MemtoReg = 2'd2; end
         9:  begin o.ALUSrcA = 1; o.PCWrite = 1; o.PCSrc = 2'd3; end
         10: begin o.ALUSrcA = 1; o.ALUSrcB = 2'd2; end
         11: begin o.IorD = 1; o.MemReq = 1; end
         12: begin o.RegWrite = 1; o.MemtoReg = 2'd1; end
         13: begin o.IorD = 1; o.MemReq = 1; o.MemWrite = 1; end
         14: begin o.ALUSrcA = 1; o.ALUOp = 3'd5; o.MulStart = 1; end
         15: begin o.ALUSrcA = 1; o.ALUOp = 3'd5; end
         16: begin o.Trap = 1; o.PCWrite = 1; end
         default: ;
      endcase
      return o;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int nxt;
         if (!rst_n) begin
            ph[i] = 0;
            wt[i] = 0;
         end else begin
            nxt = model_next(ph[i], wt[i], mem_to[i], mul_to[i], mem_ready, mul_done, opcode, funct);
            wt[i] = (nxt == ph[i]) ? wt[i] + 1 : 0;
            ph[i] = nxt;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 2; i++)
            check(i == 0 ? "model_a" : "model_b", act[i], model_out(ph[i], rst_n, mem_ready, opcode));
      end
   end

   always @(negedge clk) begin
      if (log_en) begin
         tr_a.push_back(act[0]);
         tr_b.push_back(act[1]);
      end
   end

   function automatic logic [127:0] states_of(int which);
      logic [127:0] v;
      outs_t q [$];
      v = '0;
      q = (which == 0) ? tr_a : tr_b;
      for (int k = 0; k < q.size(); k++) v = {v[122:0], q[k].State};
      return v;
   endfunction

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_test();
      log_en    = 1'b0;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      mul_done  = 1'b0;
      run(1);
      rst_n = 1'b1;
      tr_a.delete();
      tr_b.delete();
      log_en = 1'b1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0; mul_done = 1'b0;
      cmp_en = 1'b0; log_en = 1'b0;
      run(2);
      cmp_en = 1'b1;
      check("reset_state", 128'(ifa.State), 128'd0);
      check("reset_memreq", 128'(ifa.MemReq), 128'd1);

      // add: 4 cycles
      start_test();
      opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
      run(4);
      log_en = 1'b0;
      check("add_states", states_of(0), {5'd0, 5'd1, 5'd2, 5'd3});
      check("add_regwrite", {tr_a[0].RegWrite, tr_a[1].RegWrite, tr_a[2].RegWrite, tr_a[3].RegWrite}, 4'b0001);
      check("add_regdst", 128'(tr_a[3].RegDst), 128'd1);
      check("add_aluop", 128'(tr_a[2].ALUOp), 128'd2);

      // lw with wait states in FETCH (3) and MEMREAD (2)
      start_test();
      opcode = 6'h23; funct = 6'h00; mem_ready = 1'b0;
      run(3); mem_ready = 1'b1; run(1); mem_ready = 1'b0; run(4);
      mem_ready = 1'b1; run(2);
      log_en = 1'b0;
      check("lw_states", states_of(0), {5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd10, 5'd11, 5'd11, 5'd11, 5'd12});
      check("lw_states_b", states_of(1), {5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd10, 5'd11, 5'd11, 5'd11, 5'd12});
      n = 0;
      foreach (tr_a[k]) n += tr_a[k].IRWrite;
      check("lw_irwrite_pulses", 128'(n), 128'd1);
      check("lw_irwrite_at_ready", 128'(tr_a[3].IRWrite), 128'd1);

      // sw with memory stuck: timeout after 4 cycles on dut_b, 15 on dut_a
      start_test();
      opcode = 6'h2b; mem_ready = 1'b1;
      run(1); mem_ready = 1'b0; run(18);
      log_en = 1'b0;
      check("sw_b_prefix", states_of(1) >> 50, {5'd0, 5'd1, 5'd10, 5'd13, 5'd13, 5'd13, 5'd13, 5'd16, 5'd0});
      n = 0;
      foreach (tr_b[k]) if (k < 9) n += tr_b[k].MemWrite;
      check("sw_b_memwrite_cycles", 128'(n), 128'd4);
      check("sw_b_trap", {tr_b[7].Trap, tr_b[7].PCWrite, tr_b[7].PCSrc, tr_b[7].MemReq}, 5'b11000);
      n = 0;
      foreach (tr_a[k]) n += (tr_a[k].State == 5'd13);
      check("sw_a_wait_cycles", 128'(n), 128'd15);
      check("sw_a_trap", 128'(tr_a[18].State), 128'd16);

      // mult: MulDone after 6 MULWAIT cycles on dut_a; dut_b traps after 3
      start_test();
      opcode = 6'h1c; mem_ready = 1'b1;
      run(9); mul_done = 1'b1; run(1); mul_done = 1'b0; run(2);
      log_en = 1'b0;
      check("mul_states", states_of(0),
            {5'd0, 5'd1, 5'd14, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd3, 5'd0});
      n = 0;
      foreach (tr_a[k]) n += tr_a[k].MulStart;
      check("mul_start_pulses", 128'(n), 128'd1);
      check("mul_aluop", {tr_a[2].ALUOp, tr_a[5].ALUOp}, 6'b101101);
      check("mul_b_timeout", {tr_b[3].State, tr_b[4].State, tr_b[5].State, tr_b[6].State, tr_b[7].State},
            {5'd15, 5'd15, 5'd15, 5'd16, 5'd0});

      // illegal opcode
      start_test();
      opcode = 6'h3f; mem_ready = 1'b1;
      run(4);
      log_en = 1'b0;
      check("illegal_states", states_of(0), {5'd0, 5'd1, 5'd16, 5'd0});
      check("illegal_trap", 128'(tr_a[2].Trap), 128'd1);

      // jr
      start_test();
      opcode = 6'h00; funct = 6'h08; mem_ready = 1'b1;
      run(3);
      log_en = 1'b0;
      check("jr_states", states_of(0), {5'd0, 5'd1, 5'd9});
      check("jr_ctrl", {tr_a[2].PCSrc, tr_a[2].PCWrite, tr_a[2].RegWrite}, 4'b1110);

      // ori
      start_test();
      opcode = 6'h0d; funct = 6'h00; mem_ready = 1'b1;
      run(4);
      log_en = 1'b0;
      check("ori_states", states_of(0), {5'd0, 5'd1, 5'd4, 5'd5});
      check("ori_flag", {tr_a[2].Ori, tr_a[3].Ori}, 2'b11);
      check("ori_aluop", 128'(tr_a[2].ALUOp), 128'd3);

      // synchronous reset mid-MEMREAD
      start_test();
      opcode = 6'h23; mem_ready = 1'b1;
      run(1); mem_ready = 1'b0; run(3);
      rst_n = 1'b0; run(1); mem_ready = 1'b1; run(1);
      rst_n = 1'b1; log_en = 1'b0;
      check("rst_states", states_of(0), {5'd0, 5'd1, 5'd10, 5'd11, 5'd11, 5'd0});
      check("rst_ctrl_before_edge",
            {tr_a[4].MemReq, tr_a[4].IorD, tr_a[4].MemWrite, tr_a[4].RegWrite, tr_a[4].PCWrite, tr_a[4].IRWrite},
            6'b100000);
      check("rst_no_irwrite", {tr_a[5].IRWrite, tr_a[5].PCWrite, tr_a[5].MemReq}, 3'b001);
      run(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
